// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: owner state encoding,
//   default bus widths and a helper that sizes saturating counters.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef logic owner_t;

    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_DMA = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    // Bits needed to hold values 0..term (at least one bit).
    function automatic int cnt_width(input int term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_starve_counter
//   Saturating up-counter with synchronous clear. Counts 0..TERM and holds at
//   TERM; at_max flags the terminal value. Clear has priority over increment.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous, active-low reset (count -> 0)
//   clr     in  clear count at next edge
//   inc     in  increment count at next edge (saturating)
//   at_max  out count == TERM
// ---------------------------------------------------------------------------
module dmem_arbiter_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int TERM = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int W = cnt_width(TERM);

    logic [W-1:0] cnt_reg;

    assign at_max = (cnt_reg == W'(TERM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !at_max) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory between the core load/store port and a
//   DMA/debug loader port. The CPU owns the memory by default; the DMA port is
//   granted when the CPU is idle or after it has waited STARVE_MAX cycles
//   behind an active CPU. While the DMA port owns the memory the core is
//   stalled if it requests.
//
//   Optional feature macro DMEM_ARB_BURST_EN: when defined, a DMA grant may
//   carry up to BURST_LEN consecutive beats before ownership returns to the
//   CPU for at least one cycle. When undefined, each grant is a single beat
//   and BURST_LEN has no effect.
//
// Ports:
//   clk, reset                         clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_stall     core port
//   dma_req/we/addr/wdata -> dma_rdata, dma_ack       DMA port (req held until ack)
//   mem_we/addr/wdata, mem_rdata       memory side (combinational read)
//   owner_dma                          1 when the DMA port owns memory
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner_dma
);

    // Elaboration-time sanity check on the configuration.
    if (STARVE_MAX < 1 || BURST_LEN < 1) begin : g_param_check
        $error("dmem_arbiter: STARVE_MAX and BURST_LEN must be >= 1");
    end

    owner_t owner_reg;
    owner_t owner_next;

    logic wait_at_max;
    logic wait_clr;
    logic wait_inc;
    logic beat_last;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg <= OWN_CPU;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        owner_next = owner_reg;
        case (owner_reg)
            OWN_CPU: begin
                if (dma_req && (!cpu_req || wait_at_max)) begin
                    owner_next = OWN_DMA;
                end
            end
            default: begin
                // Stay only while a burst is in progress; a dropped request
                // always hands the memory straight back.
                if (!(dma_req && !beat_last)) begin
                    owner_next = OWN_CPU;
                end
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        owner_dma = (owner_reg == OWN_DMA);
        dma_ack   = owner_dma && dma_req;
        cpu_stall = owner_dma && cpu_req;
        if (owner_dma) begin
            mem_we    = dma_req && dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_we    = cpu_req && cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
        cpu_rdata = mem_rdata;
        dma_rdata = mem_rdata;
    end

    // ---------------- starvation counter ----------------
    // Counts cycles the DMA port waits behind an active CPU; cleared whenever
    // the DMA port is (or is about to be) granted.
    assign wait_inc = (owner_reg == OWN_CPU) && dma_req && cpu_req;
    assign wait_clr = (owner_reg == OWN_DMA) || (owner_next == OWN_DMA);

    dmem_arbiter_starve_counter #(
        .TERM (STARVE_MAX - 1)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .at_max (wait_at_max)
    );

`ifdef DMEM_ARB_BURST_EN
    // Beat counter: counts acked beats within one grant. When it reaches
    // BURST_LEN-1 the current beat is the last of the grant.
    logic beat_clr;
    logic beat_inc;

    assign beat_inc = (owner_reg == OWN_DMA) && dma_req;
    assign beat_clr = (owner_reg == OWN_CPU) || (owner_next == OWN_CPU);

    dmem_arbiter_starve_counter #(
        .TERM (BURST_LEN - 1)
    ) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (beat_clr),
        .inc    (beat_inc),
        .at_max (beat_last)
    );
`else
    // Single beat per grant: every beat is the last one.
    assign beat_last = 1'b1;
`endif

endmodule
